// File: rtl/ttl374_bus_arbiter_pkg.sv
// Shared types and constants for the 74LS374 bus arbiter.
package ttl_arb_pkg;
    localparam int CNTW = 4;  // burst and gap counter width

    typedef enum logic [1:0] {IDLE, OWN, GAP} arb_state_t;
endpackage

// File: rtl/ttl374_bus_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping mod N.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] idx
);
    logic [W-1:0] j;

    // Scan ptr, ptr+1, ... with explicit mod N so non-power-of-2 N wraps correctly
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = '0;
        for (int i = 0; i < N; i++) begin
            j = W'((int'(ptr) + i) % N);
            if (!valid && req[j]) begin
                valid = 1'b1;
                idx   = j;
            end
        end
    end
endmodule

// File: rtl/ttl374_bus_arbiter.sv
// Round-robin owner select for N tristate octal latches sharing one bus.
// Guarantees at least one all-released cycle (plus TURN gap cycles) between owners.
module ttl374_bus_arbiter
    import ttl_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int TURN     = 1,
    parameter int MAXBURST = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N-1:0]         REQ,
    output logic [N-1:0]         GNT,
    output logic [N-1:0]         OCn,
    output logic [$clog2(N)-1:0] OWNER,
    output logic                 BUSY
);
    localparam int W = $clog2(N);

    arb_state_t      state_q, state_d;
    logic [W-1:0]    ptr_q, ptr_d;
    logic [W-1:0]    owner_q, owner_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [CNTW-1:0] burst_q, burst_d;
    logic [CNTW-1:0] gap_q, gap_d;

    logic            pick_valid;
    logic [W-1:0]    pick_idx;
    logic            burst_hit;

    rr_pick #(.N(N), .W(W)) u_pick (
        .req   (REQ),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign burst_hit = (MAXBURST != 0) && (burst_q == CNTW'(MAXBURST));

    // Next-state: grant from IDLE, release on drop or burst limit, count the gap
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        burst_d = burst_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d           = OWN;
                    gnt_d             = '0;
                    gnt_d[pick_idx]   = 1'b1;
                    owner_d           = pick_idx;
                    burst_d           = CNTW'(1);
                end
            end
            OWN: begin
                // A simultaneous drop and burst limit is still one release
                if (!REQ[owner_q] || burst_hit) begin
                    gnt_d   = '0;
                    ptr_d   = W'((int'(owner_q) + 1) % N);
                    gap_d   = '0;
                    state_d = (TURN > 0) ? GAP : IDLE;
                end else begin
                    burst_d = (burst_q == CNTW'(15)) ? burst_q : burst_q + CNTW'(1);
                end
            end
            GAP: begin
                if (gap_q == CNTW'(TURN - 1)) state_d = IDLE;
                else                          gap_d   = gap_q + CNTW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset floats the bus on the next edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            burst_q <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            burst_q <= burst_d;
            gap_q   <= gap_d;
        end
    end

    assign GNT   = gnt_q;
    assign OCn   = ~gnt_q;
    assign OWNER = owner_q;
    assign BUSY  = (state_q == OWN);

    // Bus-safety invariants: one driver at most, and never owner-to-owner back-to-back
    always @(posedge CLK) begin
        if (!RST) begin
            assert ($onehot0(gnt_q));
            assert (BUSY == |gnt_q);
            assert (OCn == ~gnt_q);
            assert (gnt_q == '0 || gnt_d == '0 || gnt_d == gnt_q);
        end
    end
endmodule

// File: tb/tb_ttl374_bus_arbiter.sv
// Bench: three arbiter configs against a cycle-level reference, plus directed checks.
module tb_ttl374_bus_arbiter;
    localparam int NP [3] = '{4, 4, 3};
    localparam int TP [3] = '{1, 1, 0};
    localparam int MP [3] = '{8, 2, 8};

    logic       CLK = 1'b0;
    logic       rst [3];
    logic [3:0] req [3];

    logic [3:0] gnt_a, gnt_b, ocn_a, ocn_b;
    logic [2:0] gnt_c, ocn_c;
    logic [1:0] own_a, own_b, own_c;
    logic       busy_a, busy_b, busy_c;

    logic [3:0] gnt_v [3];
    logic [3:0] ocn_v [3];
    logic [1:0] own_v [3];
    logic       busy_v[3];

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    ttl374_bus_arbiter #(.N(4), .TURN(1), .MAXBURST(8)) dut_a (
        .CLK(CLK), .RST(rst[0]), .REQ(req[0]), .GNT(gnt_a), .OCn(ocn_a), .OWNER(own_a), .BUSY(busy_a));
    ttl374_bus_arbiter #(.N(4), .TURN(1), .MAXBURST(2)) dut_b (
        .CLK(CLK), .RST(rst[1]), .REQ(req[1]), .GNT(gnt_b), .OCn(ocn_b), .OWNER(own_b), .BUSY(busy_b));
    ttl374_bus_arbiter #(.N(3), .TURN(0), .MAXBURST(8)) dut_c (
        .CLK(CLK), .RST(rst[2]), .REQ(req[2][2:0]), .GNT(gnt_c), .OCn(ocn_c), .OWNER(own_c), .BUSY(busy_c));

    assign gnt_v[0] = gnt_a;  assign gnt_v[1] = gnt_b;  assign gnt_v[2] = {1'b0, gnt_c};
    assign ocn_v[0] = ocn_a;  assign ocn_v[1] = ocn_b;  assign ocn_v[2] = {1'b1, ocn_c};
    assign own_v[0] = own_a;  assign own_v[1] = own_b;  assign own_v[2] = own_c;
    assign busy_v[0] = busy_a; assign busy_v[1] = busy_b; assign busy_v[2] = busy_c;

    function automatic void chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t got=%0h want=%0h", nm, i, $time, act, exp);
        end
    endfunction

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic [2:0][3:0] g;
        logic [2:0]      b;
        logic [2:0][1:0] o;
    } exp_t;
    exp_t sbq[$];

    // Model: current owner (-1 = bus free), cycles held, quiet cycles left, next priority
    int cur [3], held [3], cool [3], nxt [3];

    always @(posedge CLK) begin : model
        exp_t e;
        int   c;
        for (int i = 0; i < 3; i++) begin
            if (rst[i]) begin
                cur[i] = -1; held[i] = 0; cool[i] = 0; nxt[i] = 0;
            end else if (cur[i] >= 0) begin
                if (!req[i][cur[i]] || (MP[i] != 0 && held[i] == MP[i])) begin
                    nxt[i]  = (cur[i] + 1) % NP[i];
                    cur[i]  = -1;
                    cool[i] = TP[i];
                end else begin
                    held[i]++;
                end
            end else if (cool[i] > 0) begin
                cool[i]--;
            end else begin
                for (int k = 0; k < NP[i]; k++) begin
                    c = (nxt[i] + k) % NP[i];
                    if (cur[i] < 0 && req[i][c]) begin
                        cur[i]  = c;
                        held[i] = 1;
                    end
                end
            end
            e.g[i] = (cur[i] >= 0) ? 4'(1 << cur[i]) : 4'd0;
            e.b[i] = (cur[i] >= 0);
            e.o[i] = (cur[i] >= 0) ? 2'(cur[i]) : 2'd0;
        end
        sbq.push_back(e);
    end

    int  zrun [3];
    bit  seen [3];
    logic [3:0] pg [3];

    // Monitor: pop expected on each negedge, compare, and check bus-safety invariants
    always @(negedge CLK) begin : mon
        exp_t e;
        logic [3:0] ng;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            for (int i = 0; i < 3; i++) begin
                chk("gnt", i, 32'(gnt_v[i]), 32'(e.g[i]));
                chk("busy", i, 32'(busy_v[i]), 32'(e.b[i]));
                if (e.b[i]) chk("owner", i, 32'(own_v[i]), 32'(e.o[i]));
                ng = ~gnt_v[i];
                chk("ocn", i, 32'(ocn_v[i]), 32'(ng));
                chk("onehot0", i, 32'($onehot0(gnt_v[i])), 32'd1);
                if (rst[i]) begin
                    seen[i] = 1'b0; zrun[i] = 0;
                end else if (gnt_v[i] != 4'd0) begin
                    if (pg[i] != 4'd0) chk("no_switch", i, 32'(gnt_v[i]), 32'(pg[i]));
                    else if (seen[i]) chk("spacing", i, 32'(zrun[i] >= TP[i] + 1), 32'd1);
                    seen[i] = 1'b1; zrun[i] = 0;
                end else begin
                    zrun[i]++;
                end
                pg[i] = gnt_v[i];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge CLK); #1;
    endtask

    task automatic wait_busy(int i, int lim);
        for (int n = 0; n < lim && !busy_v[i]; n++) cyc();
        chk("wait_busy", i, 32'(busy_v[i]), 32'd1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1);
    end

    initial begin : stim
        int hi, run, expo, w [3];
        logic prev;
        logic [3:0] pgb, pgc;
        bit had_hi;

        for (int i = 0; i < 3; i++) begin rst[i] = 1'b1; req[i] = 4'hF; end

        // reset with everyone requesting
        cyc();
        chk("rst_gnt", 0, 32'(gnt_a), 32'h0);
        chk("rst_ocn", 0, 32'(ocn_a), 32'hF);
        chk("rst_busy", 0, 32'(busy_a), 32'h0);
        cyc();
        rst[0] = 1'b0;
        cyc();
        chk("first_gnt", 0, 32'(gnt_a), 32'h1);

        // single requester on bit 2 for 3 granted cycles
        req[0] = 4'h0;
        repeat (3) cyc();
        req[0] = 4'b0100;
        hi = 0;
        for (int n = 0; n < 10; n++) begin
            cyc();
            if (gnt_a == 4'b0100) begin
                hi++;
                chk("single_ocn", 0, 32'(ocn_a), 32'hB);
                if (hi == 3) req[0] = 4'h0;
            end
        end
        chk("single_len", 0, hi, 3);
        req[0] = 4'hF;
        wait_busy(0, 5);
        chk("ptr_after", 0, 32'(own_a), 32'd3);

        // burst limit with a lone requester on bit 1
        req[0] = 4'h0;
        repeat (12) cyc();
        req[0] = 4'b0010;
        prev = 1'b0; run = 0; had_hi = 1'b0;
        for (int n = 0; n < 24; n++) begin
            cyc();
            if (gnt_a[1] == prev) run++;
            else begin
                if (prev) chk("burst_len", 0, run, 8);
                else if (had_hi) chk("burst_gap", 0, run, 2);
                run = 1;
                if (gnt_a[1]) had_hi = 1'b1;
            end
            prev = gnt_a[1];
        end

        // mid-tenure reset while owner 2 holds the bus
        req[0] = 4'h0;
        repeat (4) cyc();
        req[0] = 4'b0100;
        wait_busy(0, 6);
        chk("mid_owner", 0, 32'(own_a), 32'd2);
        rst[0] = 1'b1;
        cyc();
        chk("mid_rst_ocn", 0, 32'(ocn_a), 32'hF);
        chk("mid_rst_busy", 0, 32'(busy_a), 32'h0);
        rst[0] = 1'b0;
        req[0] = 4'b0101;
        cyc();
        chk("mid_regrant", 0, 32'(gnt_a), 32'h1);

        // fairness: all requesting, MAXBURST=2
        rst[1] = 1'b0;
        expo = 0; run = 0; pgb = 4'h0;
        for (int n = 0; n < 40; n++) begin
            cyc();
            if (gnt_b != 4'h0 && pgb == 4'h0) begin
                chk("fair_owner", 1, 32'(own_b), 32'(expo));
                expo = (expo + 1) % 4;
                run = 1;
            end else if (gnt_b != 4'h0) run++;
            else if (pgb != 4'h0) chk("fair_len", 1, run, 2);
            pgb = gnt_b;
        end

        // random traffic, N=3, TURN=0
        rst[2] = 1'b0;
        req[2] = 4'h0;
        pgc = 4'h0;
        for (int i = 0; i < 3; i++) w[i] = 0;
        for (int n = 0; n < 10000; n++) begin
            cyc();
            for (int j = 0; j < 3; j++) begin
                if (!req[2][j] || gnt_c[j]) w[j] = 0;
                else if (gnt_c != 3'd0 && pgc == 4'h0) begin
                    w[j]++;
                    chk("wait_bound", 2, 32'(w[j] <= 2), 32'd1);
                end
            end
            pgc = {1'b0, gnt_c};
            for (int j = 0; j < 3; j++)
                if ($urandom_range(5) == 0) req[2][j] = ~req[2][j];
        end

        repeat (2) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
